// File: rtl/aes_v2_issue.sv
// Issue/hold front end for the multi-cycle AES word unit: latches one op,
// holds operands across the unit latency, and buffers the result for writeback.
`timescale 1ns/1ps
module aes_v2_issue #(
  parameter bit DECRYPT_EN = 1'b1,
  parameter int TAG_W      = 5
) (
  input  logic             g_clk,
  input  logic             g_resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sub,
  input  logic             in_enc,
  input  logic [31:0]      in_rs1,
  input  logic [31:0]      in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             fu_valid,
  output logic             fu_sub,
  output logic             fu_enc,
  output logic [31:0]      fu_rs1,
  output logic [31:0]      fu_rs2,
  input  logic             fu_ready,
  input  logic [31:0]      fu_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_rd,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_RESP
  } state_e;

  state_e           state_q;
  logic             sub_q;
  logic             enc_q;
  logic [31:0]      rs1_q;
  logic [31:0]      rs2_q;
  logic [31:0]      rd_q;
  logic [TAG_W-1:0] tag_q;
  logic             err_q;
  logic             accept;
  logic             illegal;

  // Gated by reset so nothing is accepted while the block is held in reset.
  assign in_ready = g_resetn && !flush &&
                    ((state_q == S_IDLE) || ((state_q == S_RESP) && out_ready));
  assign accept   = in_valid && in_ready;
  assign illegal  = !in_enc && (DECRYPT_EN == 1'b0);

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= S_IDLE;
      sub_q   <= 1'b0;
      enc_q   <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      tag_q   <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      // An accept only happens from IDLE or a completing RESP, never under flush.
      sub_q <= in_sub;
      enc_q <= in_enc;
      rs1_q <= in_rs1;
      rs2_q <= in_rs2;
      tag_q <= in_tag;
      if (illegal) begin
        state_q <= S_RESP;
        rd_q    <= '0;
        err_q   <= 1'b1;
      end else begin
        state_q <= S_ISSUE;
        err_q   <= 1'b0;
      end
    end else begin
      case (state_q)
        S_ISSUE: state_q <= flush ? S_IDLE : S_WAIT;
        S_WAIT: begin
          if (fu_ready) begin
            if (flush) begin
              state_q <= S_IDLE;
            end else begin
              rd_q    <= fu_rd;
              err_q   <= 1'b0;
              state_q <= S_RESP;
            end
          end else if (flush) begin
            state_q <= S_DRAIN;
          end
        end
        // The unit cannot be aborted: operands stay held until it reports done.
        S_DRAIN: if (fu_ready) state_q <= S_IDLE;
        S_RESP:  if (flush || out_ready) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fu_valid  = (state_q == S_ISSUE) && !flush;
  assign fu_sub    = sub_q;
  assign fu_enc    = enc_q;
  assign fu_rs1    = rs1_q;
  assign fu_rs2    = rs2_q;
  assign out_valid = (state_q == S_RESP);
  assign out_rd    = rd_q;
  assign out_tag   = tag_q;
  assign out_err   = err_q;

endmodule

// File: doc/aes_v2_issue.md
Name: aes_v2_issue

Overview:
Issue/hold front end for the size-optimised multi-cycle AES functional unit (SubBytes/MixColumns word ops, 4-cycle latency). It accepts one AES instruction at a time from the core pipeline over a valid/ready handshake and latches the operands and function. It drives the unit with operands held stable for the whole operation and captures the result into a register. It returns the result to writeback over a second valid/ready handshake and supports pipeline flush.

Parameters:
DECRYPT_EN  1  1 = decrypt ops legal; 0 = decrypt ops complete immediately with out_err=1 and are never issued to the unit
TAG_W  5  width of the destination-register tag carried alongside each op

Ports:
g_clk  in  1  clock
g_resetn  in  1  asynchronous active-low reset
flush  in  1  kill the current op; highest priority
in_valid  in  1  instruction offered
in_ready  out  1  instruction accepted when in_valid && in_ready
in_sub  in  1  1 = SubBytes op, 0 = MixColumns op
in_enc  in  1  1 = encrypt, 0 = decrypt
in_rs1  in  32  source operand 1
in_rs2  in  32  source operand 2
in_tag  in  TAG_W  destination tag
fu_valid  out  1  start pulse to the unit
fu_sub  out  1  latched in_sub
fu_enc  out  1  latched in_enc
fu_rs1  out  32  latched in_rs1
fu_rs2  out  32  latched in_rs2
fu_ready  in  1  unit done; fu_rd is valid this cycle only
fu_rd  in  32  unit result
out_valid  out  1  result available
out_ready  in  1  writeback takes the result when out_valid && out_ready
out_rd  out  32  result word
out_tag  out  TAG_W  tag of the result
out_err  out  1  op was illegal (decrypt with DECRYPT_EN=0)

Behaviour:
- Unit contract:
  - fu_valid is asserted for exactly one cycle, only while the unit is idle.
  - fu_ready is asserted exactly 3 cycles after the fu_valid cycle.
  - fu_sub, fu_enc, fu_rs1 and fu_rs2 must stay constant from the fu_valid cycle through the fu_ready cycle inclusive.
  - The unit cannot be stalled or aborted.
- Reset (async, g_resetn=0):
  - State goes to IDLE; kill flag cleared.
  - in_ready=0, fu_valid=0, out_valid=0, out_err=0.
  - out_rd, out_tag, fu_rs1, fu_rs2, fu_sub and fu_enc all reset to 0.
  - The unit shares g_resetn, so a reset mid-operation leaves both blocks idle.
- States: IDLE, ISSUE, WAIT, DRAIN, RESP.
- in_ready = !flush && (IDLE || (RESP && out_ready)).
- Accept:
  - Operand, function and tag registers load.
  - If the op is legal, next state is ISSUE.
  - If the op is illegal, next state is RESP with out_err=1 and out_rd=0.
- ISSUE:
  - fu_valid = !flush.
  - No flush: go to WAIT.
  - flush: go to IDLE; the unit is never started.
- WAIT:
  - Hold all fu_* outputs.
  - On fu_ready: out_rd <= fu_rd, out_err <= 0, go to RESP.
  - flush before fu_ready: go to DRAIN.
  - flush in the same cycle as fu_ready: discard the result and go to IDLE.
- DRAIN:
  - Operands stay held; in_ready=0.
  - On fu_ready: discard the result and go to IDLE.
  - Further flushes in DRAIN have no effect.
- RESP:
  - out_valid=1; out_rd, out_tag and out_err are held stable until the handshake fires.
  - out_ready, no new accept: go to IDLE.
  - out_ready with a simultaneous accept: go to ISSUE or RESP per the accept rule.
  - flush: drop out_valid and go to IDLE; out_ready is ignored that cycle.
- out_valid = RESP only.
- fu_valid is never asserted outside ISSUE.
- Latency, legal op: accept at cycle N, fu_valid at N+1, fu_ready at N+4, out_valid at N+5.
  - Back-to-back throughput: one op per 5 cycles.
- Latency, illegal op: accepted at N, out_valid at N+1.
- in_valid while in_ready=0: no state change; the upstream stage holds its inputs.

Test Plan:
- Reset, then sub=1 enc=1, rs1=rs2=0x00000000, tag=7 -> fu_valid exactly at N+1; out_valid at N+5 with out_rd=0x63636363, out_tag=7, out_err=0.
- sub=1 enc=0, rs1=rs2=0x63636363 -> out_rd=0x00000000. Then sub=0 enc=1, rs1=rs2=0x01010101 -> out_rd=0x01010101.
- out_ready held low 10 cycles in RESP while in_valid=1 -> out_valid, out_rd and out_tag stable; in_ready=0. Raise out_ready with in_valid=1 -> result taken and new op accepted in the same cycle; next fu_valid one cycle later.
- flush at N+2 (WAIT) -> no out_valid, in_ready=0 until the cycle after fu_ready at N+4. Next op returns its correct result (no stale data).
- flush during ISSUE -> fu_valid=0 that cycle; IDLE next cycle. Separately, flush in RESP -> out_valid drops next cycle.
- DECRYPT_EN=0, sub=1 enc=0 -> fu_valid never asserted; out_valid at N+1 with out_err=1, out_rd=0. Async reset asserted in WAIT -> all outputs 0 immediately, state IDLE.
